// File: rtl/unsigned_seq_divider_16by8.sv
// Sequential unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define APX_TRUNC_EN to skip the TRUNC_L lowest dividend bits (approximate, shorter latency).
module unsigned_seq_divider_16by8 #(
    parameter int DW      = 16,
    parameter int VW      = 8,
    parameter int TRUNC_L = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] z,
    input  logic [VW-1:0] y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          dz
);

`ifdef APX_TRUNC_EN
    localparam int SKIP = TRUNC_L;
`else
    localparam int SKIP = 0;
`endif
    localparam int N  = DW - SKIP;
    localparam int IW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [DW-1:0] z_reg;
    logic [VW-1:0] y_reg;
    logic [VW-1:0] pr;
    logic [IW-1:0] iter;

    logic [IW-1:0] bit_idx;
    logic [VW:0]   pr_shift;
    logic          ge;
    logic [VW-1:0] diff;
    logic [VW-1:0] pr_next;

    // iter counts down over the processed bits; skipped LSBs sit below SKIP.
    assign bit_idx  = iter + IW'(SKIP);
    assign pr_shift = {pr, z_reg[bit_idx]};
    assign ge       = pr_shift >= {1'b0, y_reg};
    // The true difference is < y, so the wrapped VW-bit subtraction is exact.
    assign diff     = pr_shift[VW-1:0] - y_reg;
    assign pr_next  = ge ? diff : pr_shift[VW-1:0];

    assign in_ready = (state == IDLE) && !rst;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            z_reg     <= '0;
            y_reg     <= '0;
            pr        <= '0;
            iter      <= '0;
            q         <= '0;
            r         <= '0;
            dz        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z_reg <= z;
                        y_reg <= y;
                        pr    <= '0;
                        iter  <= IW'(N - 1);
                        if (y == '0) begin
                            q         <= '1;
                            r         <= z[VW-1:0];
                            dz        <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            q     <= '0;
                            dz    <= 1'b0;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    pr         <= pr_next;
                    q[bit_idx] <= ge;
                    if (iter == '0) begin
                        r         <= pr_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        iter <= iter - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// Directed bench for unsigned_seq_divider_16by8: hand-computed quotients/remainders,
// latency, back-to-back issue, divide-by-zero, backpressure and mid-operation reset.
module tb_unsigned_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] z;
    logic [7:0]  y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;

    int n_cmp = 0;
    int n_err = 0;

`ifdef APX_TRUNC_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 16;
`endif

    typedef struct {
        logic [15:0] zv;
        logic [7:0]  yv;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    unsigned_seq_divider_16by8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one operand pair the moment the task is entered (1 ns after an edge),
    // then wait for the result, apply backpressure if asked and complete the handshake.
    task automatic do_op(input vec_t v);
        int lat;
        check("in_ready_idle", in_ready, 1);
        z         = v.zv;
        y         = v.yv;
        in_valid  = 1'b1;
        out_ready = (v.hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        z        = 16'hA5A5;
        y        = 8'h00;
        lat      = 0;
        while (!out_valid && lat < 200) begin
            check("in_ready_busy", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, v.edz ? 0 : LAT);
        check("q", q, v.eq);
        check("r", r, v.er);
        check("dz", dz, v.edz);
        for (int k = 0; k < v.hold; k++) begin
            in_valid = k[0];
            z        = 16'd9;
            y        = 8'd2;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1);
            check("hold_q", q, v.eq);
            check("hold_r", r, v.er);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", out_valid, 0);
    endtask

    initial begin
`ifdef APX_TRUNC_EN
        vecs.push_back('{16'd45000, 8'd200, 16'd224,   8'd12,  1'b0, 0});
        vecs.push_back('{16'd1000,  8'd3,   16'd320,   8'd2,   1'b0, 0});
        vecs.push_back('{16'd65535, 8'd1,   16'd65520, 8'd0,   1'b0, 0});
        vecs.push_back('{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 0});
        vecs.push_back('{16'd500,   8'd7,   16'd64,    8'd3,   1'b0, 5});
        vecs.push_back('{16'd45434, 8'd7,   16'd6480,  8'd4,   1'b0, 0});
        vecs.push_back('{16'd65535, 8'd255, 16'd256,   8'd15,  1'b0, 0});
        vecs.push_back('{16'd1,     8'd200, 16'd0,     8'd0,   1'b0, 0});
        vecs.push_back('{16'd200,   8'd200, 16'd0,     8'd12,  1'b0, 0});
`else
        vecs.push_back('{16'd45000, 8'd200, 16'd225,   8'd0,   1'b0, 0});
        vecs.push_back('{16'd1000,  8'd3,   16'd333,   8'd1,   1'b0, 0});
        vecs.push_back('{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 0});
        vecs.push_back('{16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 0});
        vecs.push_back('{16'd500,   8'd7,   16'd71,    8'd3,   1'b0, 5});
        vecs.push_back('{16'd45434, 8'd7,   16'd6490,  8'd4,   1'b0, 0});
        vecs.push_back('{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 0});
        vecs.push_back('{16'd1,     8'd200, 16'd0,     8'd1,   1'b0, 0});
        vecs.push_back('{16'd200,   8'd200, 16'd1,     8'd0,   1'b0, 0});
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        z         = '0;
        y         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dz", dz, 0);
        rst = 1'b0;
        #1;

        // Vectors run back to back: each accept lands one cycle after the previous handshake.
        foreach (vecs[i]) do_op(vecs[i]);

        // Abort in the middle of 40000 / 9 with a one-cycle reset.
        z         = 16'd40000;
        y         = 8'd9;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready_rst", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        check("abort_in_ready", in_ready, 1);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_result", out_valid, 0);
`ifdef APX_TRUNC_EN
        do_op('{16'd40000, 8'd9, 16'd4432, 8'd7, 1'b0, 0});
`else
        do_op('{16'd40000, 8'd9, 16'd4444, 8'd4, 1'b0, 0});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
